i2c_slave_write_bit: RTL and testbench

Single-bit transmitter for the I2C slave datapath: it places one data bit on SDA while the master-driven SCL is low, holds it through the SCL high phase and releases it after a programmable hold time. It is the counterpart of `I2C_slave_read_bit`. The slave byte/ACK controller uses it to send read-data bits and ACK/NACK bits. SDA is modelled open-drain: driving 1 means release.

---
 rtl/i2c_slave_write_bit.sv | 127 ++++++++++++
 tb/tb_i2c_slave_write_bit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_write_bit.sv
// i2c_slave_write_bit
// Single-bit transmitter for the I2C slave datapath. Places one bit on SDA
// while SCL is low, holds it through SCL high, and releases it HOLD_CYCLES
// clk cycles after the SCL falling edge is detected. SDA is open-drain:
// sda_o = 1 means release.
//
// Parameters:
//   HOLD_CYCLES      clk cycles SDA stays driven after SCL fall (1..15)
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   bit_write_en     one-cycle start pulse, bit_write_i latched with it
//   bit_write_i      bit to transmit
//   bit_write_finish one-cycle pulse when the bit cycle completes
//   bit_write_err    one-cycle pulse with finish when the bit was lost
//   scl_i            synchronised SCL
//   sda_i            SDA readback
//   sda_o            SDA drive (0 pulls low, 1 releases)
// Build option:
//   I2C_SLAVE_WRITE_BIT_READBACK_EN  compiles in the SCL-high readback check;
//   when undefined sda_i is unused and bit_write_err is always 0.

module i2c_slave_write_bit #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_write_en,
    input  logic bit_write_i,
    output logic bit_write_finish,
    output logic bit_write_err,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o
);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, DRIVE, HIGH, HOLD} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state, state_nx;
    logic       scl_last;
    logic       data_r, data_nx;
    logic [3:0] cnt, cnt_nx;
    logic       fin_nx, err_nx, sda_nx;
    logic       rise, fall, loss;

    assign rise = !scl_last && scl_i;
    assign fall = scl_last && !scl_i;

`ifdef I2C_SLAVE_WRITE_BIT_READBACK_EN
    // While SCL is high the bus must read back what we put on it; a
    // mismatch means another device pulled SDA low while we released it.
    assign loss = scl_i && (sda_i != data_r);
`else
    logic unused_sda;
    assign unused_sda = sda_i;
    assign loss       = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        data_nx  = data_r;
        cnt_nx   = cnt;
        fin_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bit_write_en) begin
                    data_nx  = bit_write_i;
                    state_nx = scl_i ? WAIT_LOW : DRIVE;
                end
            end
            WAIT_LOW: begin
                if (fall) state_nx = DRIVE;
            end
            DRIVE: begin
                if (rise) state_nx = HIGH;
            end
            HIGH: begin
                if (loss) begin
                    state_nx = IDLE;
                    fin_nx   = 1'b1;
                    err_nx   = 1'b1;
                end else if (fall) begin
                    cnt_nx   = HOLD_LOAD;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                    fin_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Drive follows the current state, but release together with the
        // finish/err pulse so SDA is free the moment the controller sees it.
        sda_nx = 1'b1;
        if ((state == DRIVE || state == HIGH || state == HOLD) && state_nx != IDLE)
            sda_nx = data_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            scl_last         <= 1'b1;
            data_r           <= 1'b1;
            cnt              <= 4'd0;
            sda_o            <= 1'b1;
            bit_write_finish <= 1'b0;
            bit_write_err    <= 1'b0;
        end else begin
            state            <= state_nx;
            scl_last         <= scl_i;
            data_r           <= data_nx;
            cnt              <= cnt_nx;
            sda_o            <= sda_nx;
            bit_write_finish <= fin_nx;
            bit_write_err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_i2c_slave_write_bit.sv
// Bench for i2c_slave_write_bit: two instances (HOLD_CYCLES 2 and 3) share
// stimulus; each sees its own wired-AND SDA with an optional external pull.
module tb_i2c_slave_write_bit;

    logic clk = 1'b0;
    logic rst_n, en, bit_i, scl, pull;
    logic fin_a, err_a, sda_a, sdai_a;
    logic fin_b, err_b, sda_b, sdai_b;

    assign sdai_a = sda_a & ~pull;
    assign sdai_b = sda_b & ~pull;

    always #5 clk = ~clk;

    i2c_slave_write_bit #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bit_write_en(en), .bit_write_i(bit_i),
        .bit_write_finish(fin_a), .bit_write_err(err_a),
        .scl_i(scl), .sda_i(sdai_a), .sda_o(sda_a)
    );

    i2c_slave_write_bit #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bit_write_en(en), .bit_write_i(bit_i),
        .bit_write_finish(fin_b), .bit_write_err(err_b),
        .scl_i(scl), .sda_i(sdai_b), .sda_o(sda_b)
    );

    int          nchk = 0, nfail = 0;
    int          nfin = 0, nerr = 0;
    bit          scl_run = 1'b0;
    int          ph = 0;
    int          idx = 0;
    bit [31:0]   pat = 32'h13579bdf;
    bit [31:0]   got = 32'h0;
    bit          q[$];
`ifdef I2C_SLAVE_WRITE_BIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk cycle: wait for the falling edge, observe, then (in free-run
    // mode) advance the SCL generator: 4 cycles low, 4 cycles high.
    task automatic step();
        @(negedge clk);
        if (fin_a) nfin++;
        if (err_a) nerr++;
        if (scl_run) begin
            if (ph == 6 && q.size() > 0) begin
                bit e;
                e = q.pop_front();
                chk("main_bit", {31'b0, sda_a}, {31'b0, e});
                got = {got[30:0], sda_a};
            end
            en = 1'b0;
            if (ph == 2 && idx < 32) begin
                en    = 1'b1;
                bit_i = pat[31-idx];
                q.push_back(pat[31-idx]);
                idx++;
            end
            ph  = (ph + 1) % 8;
            scl = (ph >= 4);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; bit_i = 1'b0; scl = 1'b1; pull = 1'b0;
        step();
        step();
        chk("rst_sda", {31'b0, sda_a}, 1);
        chk("rst_fin", {31'b0, fin_a}, 0);
        chk("rst_err", {31'b0, err_a}, 0);
        chk("rst_sda3", {31'b0, sda_b}, 1);
        rst_n = 1'b1;
        step();

        // Free-running SCL, 32 back-to-back bits.
        scl = 1'b0; ph = 0; nfin = 0; nerr = 0; scl_run = 1'b1;
        for (int i = 0; i < 400 && !(idx == 32 && nfin == 32 && q.size() == 0); i++)
            step();
        scl_run = 1'b0; en = 1'b0;
        chk("main_finishes", nfin, 32);
        chk("main_errs", nerr, 0);
        chk("main_word", got, pat);
        chk("main_queue_empty", q.size(), 0);

        // Enable while SCL high, bit 0; hold timing on both instances.
        do_reset();
        scl = 1'b1; en = 1'b1; bit_i = 1'b0;
        step();
        en = 1'b0;
        chk("wl_sda_en", {31'b0, sda_a}, 1);
        step(); step();
        chk("wl_sda_high", {31'b0, sda_a}, 1);
        scl = 1'b0;
        step();
        chk("wl_sda_fall_edge", {31'b0, sda_a}, 1);
        step();
        chk("wl_sda_after_fall", {31'b0, sda_a}, 0);
        chk("wl_sda3_after_fall", {31'b0, sda_b}, 0);
        scl = 1'b1;
        step();
        step();
        chk("wl_sda_high_phase", {31'b0, sda_a}, 0);
        scl = 1'b0;
        step();
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) step();
            if (k <= 3) begin
                chk("hold2_sda", {31'b0, sda_a}, (k < 2) ? 0 : 1);
                chk("hold2_fin", {31'b0, fin_a}, (k == 2) ? 1 : 0);
            end
            chk("hold3_sda", {31'b0, sda_b}, (k < 3) ? 0 : 1);
            chk("hold3_fin", {31'b0, fin_b}, (k == 3) ? 1 : 0);
        end

        // Second enable during DRIVE is ignored.
        do_reset();
        scl = 1'b0; en = 1'b1; bit_i = 1'b0;
        step();
        en = 1'b0;
        step();
        en = 1'b1; bit_i = 1'b1;
        step();
        en = 1'b0;
        chk("ign_sda_drive", {31'b0, sda_a}, 0);
        scl = 1'b1;
        step(); step();
        chk("ign_sda_high", {31'b0, sda_a}, 0);
        scl = 1'b0; nfin = 0;
        repeat (6) step();
        chk("ign_finishes", nfin, 1);
        chk("ign_sda_end", {31'b0, sda_a}, 1);

        // External pull during SCL high while we release (bit 1).
        do_reset();
        scl = 1'b0; en = 1'b1; bit_i = 1'b1; nfin = 0; nerr = 0;
        step();
        en = 1'b0;
        step();
        scl = 1'b1;
        step(); step();
        pull = 1'b1;
        step();
        chk("rb_fin", {31'b0, fin_a}, {31'b0, RB});
        chk("rb_err", {31'b0, err_a}, {31'b0, RB});
        chk("rb_sda", {31'b0, sda_a}, 1);
        pull = 1'b0;
        step();
        chk("rb_fin_next", {31'b0, fin_a}, 0);
        chk("rb_sda_next", {31'b0, sda_a}, 1);
        scl = 1'b0;
        repeat (5) step();
        chk("rb_total_fin", nfin, 1);
        chk("rb_total_err", nerr, RB ? 1 : 0);

        // Reset during HIGH, then a normal bit.
        do_reset();
        scl = 1'b0; en = 1'b1; bit_i = 1'b0;
        step();
        en = 1'b0;
        step();
        scl = 1'b1;
        step(); step();
        chk("rstmid_sda_before", {31'b0, sda_a}, 0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_sda_async", {31'b0, sda_a}, 1);
        chk("rstmid_fin_async", {31'b0, fin_a}, 0);
        step();
        rst_n = 1'b1; scl = 1'b0; nfin = 0;
        repeat (6) step();
        chk("rstmid_no_finish", nfin, 0);
        en = 1'b1; bit_i = 1'b0;
        step();
        en = 1'b0;
        step();
        chk("rstmid_next_sda", {31'b0, sda_a}, 0);
        scl = 1'b1;
        step(); step();
        scl = 1'b0;
        repeat (5) step();
        chk("rstmid_next_fin", nfin, 1);
        chk("rstmid_next_sda_end", {31'b0, sda_a}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
